// File: rtl/cotm32_priv_pkg.sv
// Privilege/trap types shared by the cotm32 trap controller and its interrupt arbiter.
// Cause constants and the irq_select priority encoder live here so WFI wakeup logic can reuse them.
package cotm32_priv_pkg;

   localparam int XLEN  = 32;
   localparam int MXLEN = 32;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_mode_t;

   typedef struct packed {
      logic             irq;
      logic [MXLEN-2:0] code;
   } trap_cause_t;

   typedef enum logic [1:0] {
      IDLE,
      TRAP_SAVE,
      TRAP_JUMP,
      RET_JUMP
   } trap_state_t;

   localparam trap_cause_t TRAP_CAUSE_M_SOFT_INT  = {1'b1, 31'd3};
   localparam trap_cause_t TRAP_CAUSE_M_TIMER_INT = {1'b1, 31'd7};
   localparam trap_cause_t TRAP_CAUSE_M_EXT_INT   = {1'b1, 31'd11};

   // pending = {MEI, MSI, MTI}; MEI wins, then MSI, then MTI.
   function automatic trap_cause_t irq_select(input logic [2:0] pending);
      trap_cause_t cause;
      cause = '0;
      if (pending[2])      cause = TRAP_CAUSE_M_EXT_INT;
      else if (pending[1]) cause = TRAP_CAUSE_M_SOFT_INT;
      else if (pending[0]) cause = TRAP_CAUSE_M_TIMER_INT;
      return cause;
   endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational priority encoder from the masked machine interrupt pending vector to an mcause value.
module irq_arbiter
   import cotm32_priv_pkg::*;
(
   input  logic [2:0]  i_irq_pending,
   output logic        o_irq_any,
   output trap_cause_t o_irq_cause
);

   assign o_irq_any   = |i_irq_pending;
   assign o_irq_cause = irq_select(i_irq_pending);

endmodule

// File: rtl/trap_controller.sv
// Commit-point trap/MRET sequencer for cotm32: arbitrates interrupts vs exceptions vs MRET,
// strobes the CSR file, redirects fetch and owns privilege. COTM32_TRAP_VECTORED_EN enables vectored mtvec.
module trap_controller
   import cotm32_priv_pkg::*;
#(
   parameter priv_mode_t RESET_PRIV = PRIV_M
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_inst_valid,
   input  logic [XLEN-1:0]   i_pc,
   input  logic              i_exception_req,
   input  trap_cause_t       i_exception_cause,
   input  logic [MXLEN-1:0]  i_exception_tval,
   input  logic              i_mret,
   input  logic [2:0]        i_irq_pending,
   input  logic              i_mstatus_mie,
   input  priv_mode_t        i_mstatus_mpp,
   input  logic [MXLEN-1:0]  i_mtvec,
   input  logic [MXLEN-1:0]  i_mepc,
   output logic              o_kill,
   output logic              o_stall,
   output logic              o_csr_trap_we,
   output logic [MXLEN-1:0]  o_trap_mepc,
   output trap_cause_t       o_trap_mcause,
   output logic [MXLEN-1:0]  o_trap_mtval,
   output logic              o_csr_mret_we,
   output logic              o_redirect,
   output logic [XLEN-1:0]   o_redirect_pc,
   output priv_mode_t        o_priv_mode
);

   trap_state_t      state_q,  state_d;
   priv_mode_t       priv_q,   priv_d;
   logic [MXLEN-1:0] mepc_q,   mepc_d;
   trap_cause_t      mcause_q, mcause_d;
   logic [MXLEN-1:0] mtval_q,  mtval_d;

   logic             irq_any;
   trap_cause_t      irq_cause;
   logic             irq_en;
   logic [XLEN-1:0]  trap_base;
   logic [XLEN-1:0]  trap_target;
   logic             unused_mode_bits;

   irq_arbiter u_irq_arbiter (
      .i_irq_pending (i_irq_pending),
      .o_irq_any     (irq_any),
      .o_irq_cause   (irq_cause)
   );

   // U-mode code is always interruptible by M-mode interrupts regardless of MIE.
   assign irq_en    = (i_mstatus_mie | (priv_q == PRIV_U)) & irq_any;
   assign trap_base = {i_mtvec[MXLEN-1:2], 2'b00};

`ifdef COTM32_TRAP_VECTORED_EN
   assign trap_target = ((i_mtvec[1:0] == 2'b01) && mcause_q.irq)
                      ? trap_base + {mcause_q.code[MXLEN-3:0], 2'b00}
                      : trap_base;
`else
   assign trap_target = trap_base;
`endif

   assign unused_mode_bits = ^{i_mtvec[1:0], i_mepc[1:0]};

   always_comb begin
      state_d       = state_q;
      priv_d        = priv_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      o_kill        = 1'b0;
      o_stall       = 1'b0;
      o_csr_trap_we = 1'b0;
      o_csr_mret_we = 1'b0;
      o_redirect    = 1'b0;
      o_redirect_pc = '0;
      unique case (state_q)
         IDLE: begin
            if (i_inst_valid) begin
               if (irq_en) begin
                  o_kill   = 1'b1;
                  mepc_d   = i_pc;
                  mcause_d = irq_cause;
                  mtval_d  = '0;
                  state_d  = TRAP_SAVE;
               end else if (i_exception_req) begin
                  o_kill   = 1'b1;
                  mepc_d   = i_pc;
                  mcause_d = i_exception_cause;
                  mtval_d  = i_exception_tval;
                  state_d  = TRAP_SAVE;
               end else if (i_mret) begin
                  o_kill   = 1'b1;
                  state_d  = RET_JUMP;
               end
            end
         end
         TRAP_SAVE: begin
            o_csr_trap_we = 1'b1;
            o_stall       = 1'b1;
            state_d       = TRAP_JUMP;
         end
         TRAP_JUMP: begin
            o_redirect    = 1'b1;
            o_stall       = 1'b1;
            o_redirect_pc = trap_target;
            priv_d        = PRIV_M;
            state_d       = IDLE;
         end
         RET_JUMP: begin
            o_csr_mret_we = 1'b1;
            o_redirect    = 1'b1;
            o_stall       = 1'b1;
            o_redirect_pc = {i_mepc[XLEN-1:2], 2'b00};
            // MPP is sampled before the CSR file consumes the MRET strobe.
            priv_d        = i_mstatus_mpp;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         priv_q   <= RESET_PRIV;
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
      end else begin
         state_q  <= state_d;
         priv_q   <= priv_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mtval_q  <= mtval_d;
      end
   end

   assign o_trap_mepc   = mepc_q;
   assign o_trap_mcause = mcause_q;
   assign o_trap_mtval  = mtval_q;
   assign o_priv_mode   = priv_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: stimulus queues expected strobe events, a negedge monitor checks them.
module tb_trap_controller;
   import cotm32_priv_pkg::*;

   localparam int K_KILL  = 1;
   localparam int K_TRAP  = 2;
   localparam int K_MRET  = 3;
   localparam int K_REDIR = 4;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } exp_t;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_inst_valid = 1'b0;
   logic [31:0]       i_pc = '0;
   logic              i_exception_req = 1'b0;
   trap_cause_t       i_exception_cause = '0;
   logic [31:0]       i_exception_tval = '0;
   logic              i_mret = 1'b0;
   logic [2:0]        i_irq_pending = '0;
   logic              i_mstatus_mie = 1'b0;
   priv_mode_t        i_mstatus_mpp = PRIV_M;
   logic [31:0]       i_mtvec = '0;
   logic [31:0]       i_mepc = '0;
   logic              o_kill, o_stall, o_csr_trap_we, o_csr_mret_we, o_redirect;
   logic [31:0]       o_trap_mepc, o_trap_mtval, o_redirect_pc;
   trap_cause_t       o_trap_mcause;
   priv_mode_t        o_priv_mode;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   bit   priv_pend = 1'b0;
   logic [31:0] exp_priv = '0;

   trap_controller dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_inst_valid      (i_inst_valid),
      .i_pc              (i_pc),
      .i_exception_req   (i_exception_req),
      .i_exception_cause (i_exception_cause),
      .i_exception_tval  (i_exception_tval),
      .i_mret            (i_mret),
      .i_irq_pending     (i_irq_pending),
      .i_mstatus_mie     (i_mstatus_mie),
      .i_mstatus_mpp     (i_mstatus_mpp),
      .i_mtvec           (i_mtvec),
      .i_mepc            (i_mepc),
      .o_kill            (o_kill),
      .o_stall           (o_stall),
      .o_csr_trap_we     (o_csr_trap_we),
      .o_trap_mepc       (o_trap_mepc),
      .o_trap_mcause     (o_trap_mcause),
      .o_trap_mtval      (o_trap_mtval),
      .o_csr_mret_we     (o_csr_mret_we),
      .o_redirect        (o_redirect),
      .o_redirect_pc     (o_redirect_pc),
      .o_priv_mode       (o_priv_mode)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      exp_t e;
      e.kind = kind; e.a = a; e.b = b; e.c = c;
      sbq.push_back(e);
   endtask

   task automatic take(input int kind, output exp_t e, output bit ok);
      ok = 1'b0;
      e.kind = 0; e.a = '0; e.b = '0; e.c = '0;
      if (sbq.size() == 0) begin
         check("unexpected_event", kind, 0);
      end else begin
         e = sbq.pop_front();
         check("event_kind", kind, e.kind);
         ok = (e.kind == kind);
      end
   endtask

   initial begin : monitor
      exp_t e;
      bit   ok;
      forever begin
         @(negedge i_clk);
         if (priv_pend) begin
            check("priv_after_redirect", {30'b0, o_priv_mode}, exp_priv);
            priv_pend = 1'b0;
         end
         if (o_kill) take(K_KILL, e, ok);
         if (o_csr_trap_we) begin
            take(K_TRAP, e, ok);
            if (ok) begin
               check("trap_mepc", o_trap_mepc, e.a);
               check("trap_mcause", o_trap_mcause, e.b);
               check("trap_mtval", o_trap_mtval, e.c);
            end
         end
         if (o_csr_mret_we) take(K_MRET, e, ok);
         if (o_redirect) begin
            take(K_REDIR, e, ok);
            if (ok) begin
               check("redirect_pc", o_redirect_pc, e.a);
               check("stall_in_jump", {31'b0, o_stall}, 32'd1);
               exp_priv  = e.b;
               priv_pend = 1'b1;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
   endtask

   task automatic commit(input logic [31:0] pc, input logic exc, input logic [31:0] cause,
                         input logic [31:0] tval, input logic mret);
      @(posedge i_clk); #1;
      i_pc = pc; i_exception_req = exc; i_exception_cause = cause;
      i_exception_tval = tval; i_mret = mret; i_inst_valid = 1'b1;
      @(posedge i_clk); #1;
      i_inst_valid = 1'b0; i_exception_req = 1'b0; i_mret = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [31:0] vec_exp;
      #12;
      check("rst_kill", {31'b0, o_kill}, 0);
      check("rst_trap_we", {31'b0, o_csr_trap_we}, 0);
      check("rst_redirect", {31'b0, o_redirect}, 0);
      check("rst_mepc", o_trap_mepc, 0);
      check("rst_priv", {30'b0, o_priv_mode}, 32'h3);
      i_rst_n = 1'b1;
      i_mtvec = 32'h200;
      idle(2);

      // Illegal instruction.
      push(K_KILL, 0, 0, 0);
      push(K_TRAP, 32'h100, 32'd2, 32'h0000_FFFF);
      push(K_REDIR, 32'h200, 32'h3, 0);
      commit(32'h100, 1'b1, 32'd2, 32'h0000_FFFF, 1'b0);
      idle(3);

      // All interrupts pending with MIE plus a simultaneous exception: MEI wins.
      i_irq_pending = 3'b111; i_mstatus_mie = 1'b1;
      push(K_KILL, 0, 0, 0);
      push(K_TRAP, 32'h40, 32'h8000_000B, 0);
      push(K_REDIR, 32'h200, 32'h3, 0);
      commit(32'h40, 1'b1, 32'd2, 32'h55, 1'b0);
      i_irq_pending = 3'b000;
      idle(3);

      // MRET to U with misaligned mepc.
      i_mepc = 32'h1234_5679; i_mstatus_mpp = PRIV_U;
      push(K_KILL, 0, 0, 0);
      push(K_MRET, 0, 0, 0);
      push(K_REDIR, 32'h1234_5678, 32'h0, 0);
      commit(32'h80, 1'b0, 0, 0, 1'b1);
      idle(3);

      // U-mode ignores MIE=0: MTI taken.
      i_mstatus_mie = 1'b0; i_irq_pending = 3'b001; i_mstatus_mpp = PRIV_M;
      push(K_KILL, 0, 0, 0);
      push(K_TRAP, 32'h300, 32'h8000_0007, 0);
      push(K_REDIR, 32'h200, 32'h3, 0);
      commit(32'h300, 1'b0, 0, 0, 1'b0);
      idle(3);

      // M-mode with MIE=0: MTI masked, no kill.
      @(posedge i_clk); #1;
      i_pc = 32'h304; i_inst_valid = 1'b1;
      #1 check("masked_irq_no_kill", {31'b0, o_kill}, 0);
      @(posedge i_clk); #1;
      i_inst_valid = 1'b0;
      // MIE=1 but no committing instruction: no action.
      i_mstatus_mie = 1'b1;
      idle(3);
      i_irq_pending = 3'b000;

      // MEI with mtvec in vectored mode.
      i_mtvec = 32'h1001; i_irq_pending = 3'b100;
`ifdef COTM32_TRAP_VECTORED_EN
      vec_exp = 32'h102C;
`else
      vec_exp = 32'h1000;
`endif
      push(K_KILL, 0, 0, 0);
      push(K_TRAP, 32'h500, 32'h8000_000B, 0);
      push(K_REDIR, vec_exp, 32'h3, 0);
      commit(32'h500, 1'b0, 0, 0, 1'b0);
      i_irq_pending = 3'b000;
      idle(3);

      // Drop to U, then reset in the middle of TRAP_SAVE.
      i_mepc = 32'h800; i_mstatus_mpp = PRIV_U;
      push(K_KILL, 0, 0, 0);
      push(K_MRET, 0, 0, 0);
      push(K_REDIR, 32'h800, 32'h0, 0);
      commit(32'h600, 1'b0, 0, 0, 1'b1);
      idle(3);
      check("priv_before_reset", {30'b0, o_priv_mode}, 32'h0);
      push(K_KILL, 0, 0, 0);
      commit(32'h900, 1'b1, 32'd2, 32'h77, 1'b0);
      i_rst_n = 1'b0;
      #1;
      check("midrst_trap_we", {31'b0, o_csr_trap_we}, 0);
      check("midrst_stall", {31'b0, o_stall}, 0);
      check("midrst_redirect", {31'b0, o_redirect}, 0);
      check("midrst_mepc", o_trap_mepc, 0);
      check("midrst_mcause", o_trap_mcause, 0);
      check("midrst_mtval", o_trap_mtval, 0);
      check("midrst_priv", {30'b0, o_priv_mode}, 32'h3);
      idle(2); #3;
      i_rst_n = 1'b1;
      idle(5);

      check("scoreboard_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequences synchronous exceptions, machine interrupts and MRET at the commit point of the cotm32 core.
- Arbitrates a pending interrupt against the exception request produced by exception dispatch for the committing instruction.
- Drives the CSR file trap-entry and MRET update strobes, computes the redirect PC from mtvec/mepc, and owns the current privilege-mode register.

Parameters:
- RESET_PRIV, PRIV_M, privilege mode after reset.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_inst_valid  in  1  committing instruction valid
- i_pc  in  XLEN  PC of committing instruction
- i_exception_req  in  1  exception request for committing instruction
- i_exception_cause  in  trap_cause_t  exception cause
- i_exception_tval  in  MXLEN  exception tval
- i_mret  in  1  committing instruction is MRET (legal, already checked)
- i_irq_pending  in  3  {MEI,MSI,MTI}, already ANDed with mie
- i_mstatus_mie  in  1  mstatus.MIE
- i_mstatus_mpp  in  priv_mode_t  mstatus.MPP
- i_mtvec  in  MXLEN  mtvec CSR
- i_mepc  in  MXLEN  mepc CSR
- o_kill  out  1  suppress committing instruction's side effects (combinational)
- o_stall  out  1  hold pipeline
- o_csr_trap_we  out  1  one-cycle trap-entry strobe to CSR file
- o_trap_mepc  out  MXLEN  value for mepc
- o_trap_mcause  out  trap_cause_t  value for mcause
- o_trap_mtval  out  MXLEN  value for mtval
- o_csr_mret_we  out  1  one-cycle MRET strobe (CSR file restores MIE/MPIE/MPP)
- o_redirect  out  1  fetch redirect + pipeline flush
- o_redirect_pc  out  XLEN  redirect target
- o_priv_mode  out  priv_mode_t  current privilege

Behaviour:
- FSM states: IDLE, TRAP_SAVE, TRAP_JUMP, RET_JUMP.
- Reset values: state IDLE; priv = RESET_PRIV; all strobes 0; captured mepc/mcause/mtval = 0.
- Reset mid-sequence returns to IDLE immediately. No partial CSR strobe is emitted after reset.
- Interrupt enable in IDLE: irq_en = (i_mstatus_mie | priv==PRIV_U) & |i_irq_pending.
- Interrupt priority: MEI (code 11) > MSI (3) > MTI (7). Interrupt mcause has MSB set; tval = 0.
- Arbitration in IDLE with i_inst_valid=1. Priority: interrupt > exception > MRET.
  - Interrupt: taken before the instruction executes. Capture mepc = i_pc. Go TRAP_SAVE.
  - Exception: capture mepc = i_pc and the cause/tval from the inputs. Go TRAP_SAVE.
  - MRET: go RET_JUMP.
  - In all three cases o_kill = 1 in the same cycle (combinational). o_stall is 0 in IDLE.
  - With i_inst_valid=0: no action, and no interrupt is taken.
- TRAP_SAVE (1 cycle): o_csr_trap_we = 1, o_stall = 1. o_trap_* hold the captured values. Next: TRAP_JUMP.
- TRAP_JUMP (1 cycle):
  - o_redirect = 1, o_stall = 1.
  - o_redirect_pc = {i_mtvec[MXLEN-1:2], 2'b00}; i_mtvec[1:0] is ignored unless the optional feature is enabled.
  - priv <= PRIV_M at end of cycle. Next: IDLE.
- RET_JUMP (1 cycle):
  - o_csr_mret_we = 1, o_redirect = 1, o_stall = 1.
  - o_redirect_pc = {i_mepc[XLEN-1:2], 2'b00}.
  - priv <= i_mstatus_mpp, sampled this cycle, before the CSR file updates it. Next: IDLE.
- Latency: trap detect to redirect = 2 cycles; MRET detect to redirect = 1 cycle.
- All request inputs are ignored outside IDLE. Pipeline is stalled, so requests are re-presented after the flush.
- o_trap_* outputs are registered and stable from TRAP_SAVE through TRAP_JUMP.
- An interrupt arriving during RET_JUMP is evaluated in the next IDLE cycle with the updated MIE.

Optional Feature:
- Macro: COTM32_TRAP_VECTORED_EN.
- Defined: when i_mtvec[1:0]==2'b01 and the captured cause is an interrupt, TRAP_JUMP target = {mtvec base,00} + 4*cause_code. mtvec mode 2'b1x is treated as direct.
- Undefined: always direct mode; mode bits ignored.

Decomposition:
- Goes in cotm32_priv_pkg:
  - typedef trap_state_t.
  - Interrupt cause constants TRAP_CAUSE_M_SOFT_INT/M_TIMER_INT/M_EXT_INT.
  - Function irq_select (priority encode to trap_cause_t).
- Sub-module irq_arbiter (combinational pending-to-cause priority encoder); it is natural to split out for reuse in WFI wakeup.

Test Plan:
- Illegal inst at i_pc=0x100, tval=0x0000FFFF, mtvec=0x200 -> cycle0 o_kill; cycle1 o_csr_trap_we, mcause=2, mepc=0x100, mtval=0xFFFF; cycle2 o_redirect to 0x200, priv=M.
- i_irq_pending=3'b111 with MIE=1 and simultaneous exception at pc 0x40 -> mcause=0x8000000B, mepc=0x40, mtval=0; the exception is discarded.
- Priv=U, MIE=0, MTI pending -> trap taken, mcause=0x80000007. Priv=M, MIE=0 -> no trap, o_kill=0.
- MRET with mepc=0x1234_5679, MPP=U -> o_kill; next cycle o_csr_mret_we, redirect 0x1234_5678; priv=U afterwards.
- With COTM32_TRAP_VECTORED_EN, mtvec=0x1001, MEI -> redirect 0x102C. Without the macro -> redirect 0x1000.
- Assert i_rst_n low during TRAP_SAVE -> all outputs 0 immediately, priv=M, no redirect after release.
